// File: rtl/serial_frame_tx.sv
// Framing transmitter: takes a parallel word, waits for the downstream detector,
// then sends a start pulse, preamble, MSB-first payload and an idle gap serially.
module serial_frame_tx #(
  parameter int unsigned      DATA_W  = 8,
  parameter int unsigned      PRE_W   = 4,
  parameter logic [PRE_W-1:0] PRE     = 4'b1101,
  parameter int unsigned      GAP_CYC = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready_in,
  output logic              start,
  output logic              serialout,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MAX_LEN = (PRE_W > DATA_W)
                                    ? ((PRE_W > GAP_CYC) ? PRE_W : GAP_CYC)
                                    : ((DATA_W > GAP_CYC) ? DATA_W : GAP_CYC);
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_PRE   = 3'd3,
    S_DATA  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [DATA_W-1:0]  sreg_q, sreg_n;
  logic [PRE_W-1:0]   pre_q, pre_n;
  logic               start_n, ser_n, busy_n, done_n;

  // Next-state and next-output decode; outputs describe the state being entered.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    sreg_n  = sreg_q;
    pre_n   = pre_q;
    start_n = 1'b0;
    ser_n   = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_n = 1'b0;
        if (load) begin
          sreg_n  = data_in;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = S_WAIT;
        end
      end

      S_WAIT: begin
        if (ready_in) begin
          start_n = 1'b1;
          cnt_n   = '0;
          state_n = S_START;
        end
      end

      S_START: begin
        ser_n   = PRE[PRE_W-1];
        pre_n   = PRE << 1;
        cnt_n   = CNT_W'(PRE_W - 1);
        state_n = S_PRE;
      end

      S_PRE: begin
        if (cnt_q == '0) begin
          // Last preamble bit done: present payload MSB on entry to DATA.
          ser_n   = sreg_q[DATA_W-1];
          sreg_n  = sreg_q << 1;
          cnt_n   = CNT_W'(DATA_W - 1);
          state_n = S_DATA;
        end else begin
          ser_n = pre_q[PRE_W-1];
          pre_n = pre_q << 1;
          cnt_n = cnt_q - CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_n   = CNT_W'(GAP_CYC - 1);
          state_n = S_GAP;
        end else begin
          ser_n  = sreg_q[DATA_W-1];
          sreg_n = sreg_q << 1;
          cnt_n  = cnt_q - CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        busy_n  = 1'b0;
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sreg_q    <= '0;
      pre_q     <= '0;
      start     <= 1'b0;
      serialout <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      sreg_q    <= sreg_n;
      pre_q     <= pre_n;
      start     <= start_n;
      serialout <= ser_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: stimulus tables (directed and random) are replayed
// against a frame-timeline reference model computed from the frame format.
module tb_serial_frame_tx;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PRE_W   = 4;
  localparam logic [PRE_W-1:0] PRE = 4'b1101;
  localparam int unsigned GAP_CYC = 2;
  localparam int          N       = 256;
  localparam int          FLEN    = PRE_W + DATA_W;

  logic              clock;
  logic              rst;
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic              ready_in;
  logic              start;
  logic              serialout;
  logic              busy;
  logic              done;

  int n_cmp;
  int n_err;

  // Stimulus tables and expected/actual {start, serialout, busy, done} per cycle.
  bit                ld  [N];
  logic [DATA_W-1:0] dat [N];
  bit                rdy [N];
  logic [3:0]        expv[N];
  logic [3:0]        actv[N];

  serial_frame_tx #(
    .DATA_W (DATA_W),
    .PRE_W  (PRE_W),
    .PRE    (PRE),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clock    (clock),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in),
    .ready_in (ready_in),
    .start    (start),
    .serialout(serialout),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c < N; c++) begin
      ld[c]  = 1'b0;
      dat[c] = DATA_W'($urandom);
      rdy[c] = 1'b1;
    end
  endtask

  task automatic rand_stim();
    for (int c = 0; c < N; c++) begin
      ld[c]  = (c < N - 50) && ($urandom_range(0, 5) == 0);
      dat[c] = DATA_W'($urandom);
      rdy[c] = (c >= N - 50) || ($urandom_range(0, 2) != 0);
    end
  endtask

  // Reference: lay each accepted frame onto a cycle timeline.
  task automatic build_model();
    int free_c;
    int w;
    int s;
    int d;
    logic [FLEN-1:0] bits;
    free_c = 0;
    for (int c = 0; c < N; c++) expv[c] = 4'b0000;
    for (int c = 0; c < N; c++) begin
      if (c < free_c || !ld[c]) continue;
      bits = {PRE, dat[c]};
      w = c + 1;
      while (w < N && !rdy[w]) begin
        expv[w][1] = 1'b1;
        w++;
      end
      if (w + FLEN + GAP_CYC + 2 >= N) begin
        free_c = N;
        break;
      end
      expv[w][1] = 1'b1;
      s = w + 1;
      expv[s][3] = 1'b1;
      expv[s][1] = 1'b1;
      for (int i = 0; i < FLEN; i++) begin
        expv[s + 1 + i][2] = bits[FLEN - 1 - i];
        expv[s + 1 + i][1] = 1'b1;
      end
      for (int g = 0; g < int'(GAP_CYC); g++) expv[s + 1 + FLEN + g][1] = 1'b1;
      d = s + 1 + FLEN + int'(GAP_CYC);
      expv[d][0] = 1'b1;
      free_c = d;
    end
  endtask

  // Reset with random inputs, release, then replay the tables cycle by cycle.
  task automatic run_seq(input string name);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      load     = 1'($urandom);
      data_in  = DATA_W'($urandom);
      ready_in = 1'($urandom);
      @(negedge clock);
      check_eq($sformatf("%s rst_hold%0d", name, k), {start, serialout, busy, done}, 4'b0000);
    end
    load     = 1'b0;
    ready_in = 1'b0;
    rst      = 1'b1;
    for (int c = 0; c < N; c++) begin
      @(posedge clock);
      #1;
      load     = ld[c];
      data_in  = dat[c];
      ready_in = rdy[c];
      @(negedge clock);
      actv[c] = {start, serialout, busy, done};
      check_eq($sformatf("%s c%0d", name, c), actv[c], expv[c]);
    end
  endtask

  function automatic int count_bit(input int b);
    int n;
    n = 0;
    for (int c = 0; c < N; c++) n += int'(actv[c][b]);
    return n;
  endfunction

  function automatic logic [FLEN-1:0] serial_at(input int first);
    logic [FLEN-1:0] v;
    v = '0;
    for (int i = 0; i < FLEN; i++) v = {v[FLEN-2:0], actv[first + i][2]};
    return v;
  endfunction

  // Abort a frame with reset during payload bit 3 and confirm no done follows.
  task automatic mid_abort();
    int dn;
    rst      = 1'b0;
    load     = 1'b0;
    ready_in = 1'b1;
    data_in  = '0;
    @(negedge clock);
    rst = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(posedge clock);
      #1;
      load     = (c == 2);
      data_in  = 8'hA5;
      ready_in = 1'b1;
      @(negedge clock);
    end
    check_eq("abort busy_before", 32'(busy), 32'd1);
    check_eq("abort bit3", 32'(serialout), 32'd0);
    #2 rst = 1'b0;
    #1 check_eq("abort immediate", {start, serialout, busy, done}, 4'b0000);
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      dn += int'(done);
    end
    check_eq("abort no_done", 32'(dn), 32'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    load     = 1'b0;
    data_in  = '0;
    ready_in = 1'b0;

    // Basic frame, load in cycle 2.
    clear_stim();
    ld[2] = 1'b1; dat[2] = 8'hA5;
    build_model();
    run_seq("basic");
    check_eq("basic start_c4", 32'(actv[4][3]), 32'd1);
    check_eq("basic serial", 32'(serial_at(5)), 32'hDA5);
    check_eq("basic done_c19", 32'(actv[19][0]), 32'd1);
    check_eq("basic busy_cycles", 32'(count_bit(1)), 32'd16);

    // Ready stalled for 5 cycles after load.
    clear_stim();
    ld[2] = 1'b1; dat[2] = 8'hA5;
    for (int c = 3; c < 8; c++) rdy[c] = 1'b0;
    build_model();
    run_seq("stall");
    check_eq("stall start_c9", 32'(actv[9][3]), 32'd1);
    check_eq("stall serial", 32'(serial_at(10)), 32'hDA5);
    check_eq("stall starts", 32'(count_bit(3)), 32'd1);

    // Load pulse while the payload of another frame is going out.
    clear_stim();
    ld[2] = 1'b1;  dat[2]  = 8'h3C;
    ld[12] = 1'b1; dat[12] = 8'hFF;
    build_model();
    run_seq("ldbusy");
    check_eq("ldbusy serial", 32'(serial_at(5)), 32'hD3C);
    check_eq("ldbusy starts", 32'(count_bit(3)), 32'd1);
    check_eq("ldbusy dones", 32'(count_bit(0)), 32'd1);

    // Back-to-back: second load held through the done cycle.
    clear_stim();
    ld[2] = 1'b1; dat[2] = 8'h81;
    for (int c = 3; c < 20; c++) begin
      ld[c]  = 1'b1;
      dat[c] = 8'h7E;
    end
    build_model();
    run_seq("b2b");
    check_eq("b2b start1_c4", 32'(actv[4][3]), 32'd1);
    check_eq("b2b start2_c21", 32'(actv[21][3]), 32'd1);
    check_eq("b2b serial1", 32'(serial_at(5)), 32'hD81);
    check_eq("b2b serial2", 32'(serial_at(22)), 32'hD7E);

    // Reset mid-frame, then a fresh frame must be complete.
    mid_abort();
    clear_stim();
    ld[2] = 1'b1; dat[2] = 8'h5A;
    build_model();
    run_seq("post_abort");
    check_eq("post_abort serial", 32'(serial_at(5)), 32'hD5A);

    // Random load/data/ready traffic.
    for (int r = 0; r < 5; r++) begin
      rand_stim();
      build_model();
      run_seq($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Upstream framing stage for the serial pattern detector/counter. Accepts a parallel data word through a load handshake, waits until the downstream detector reports ready, then drives a one-cycle `start` pulse followed by a bit-serial frame on `serialout`. The frame is a fixed preamble matching the detector's pattern, then the data word MSB-first, then an idle gap. Its `start` and `serialout` connect directly to the detector's `start` and `serialin`; the detector's `ready` feeds back to `ready_in`.

## Interface
- `DATA_W`, default 8: payload width in bits.
- `PRE_W`, default 4: preamble width in bits.
- `PRE`, default 4'b1101: preamble pattern, sent MSB-first; must equal the detector's pattern.
- `GAP_CYC`, default 2: number of idle zero cycles after the payload; must be at least 1.
- `clock`, in, 1: single clock; rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `load`, in, 1: request to send `data_in`; sampled only in IDLE.
- `data_in`, in, DATA_W: payload, captured on the edge where `load` is accepted.
- `ready_in`, in, 1: detector ready; level-sensitive.
- `start`, out, 1: one-cycle pulse marking frame start.
- `serialout`, out, 1: serial frame bit.
- `busy`, out, 1: high from acceptance through the last gap cycle.
- `done`, out, 1: one-cycle pulse on return to IDLE after a completed frame.

## Operation
- All outputs are registered. Reset values: `start`=0, `serialout`=0, `busy`=0, `done`=0, state=IDLE, shift register=0, bit counter=0.
- FSM states: IDLE, WAIT, START, PRE, DATA, GAP.
- IDLE:
  - `busy`=0.
  - `load`=1 at an edge: capture `data_in` into the shift register and go to WAIT.
- WAIT:
  - `busy`=1, `serialout`=0.
  - `ready_in`=1 at an edge: go to START. Otherwise stay in WAIT indefinitely.
- START: `start`=1 and `serialout`=0 for exactly one cycle, then PRE.
- PRE: `serialout` = `PRE[PRE_W-1]` down to `PRE[0]`, one bit per cycle, PRE_W cycles, then DATA.
- DATA: `serialout` = payload MSB first, one bit per cycle, DATA_W cycles; the shift register shifts left each cycle. Then GAP.
- GAP: `serialout`=0 for GAP_CYC cycles, then IDLE with `done`=1 for that first IDLE cycle.
- Bit counter: width `$clog2(max(PRE_W,DATA_W,GAP_CYC)+1)`. It is reloaded on every state entry and counts down, so it never wraps.
- `load` outside IDLE is ignored; `data_in` changes outside the capture edge have no effect.
- `ready_in` is only sampled in WAIT. Dropping it after START does not abort the frame.
- Asserting `rst` at any point, including mid-frame, immediately forces the reset values asynchronously and discards the frame. No `done` is produced for an aborted frame.
- `load`=1 in the same cycle that `done`=1 is accepted, so back-to-back frames are possible.

## Timing
- Cycle numbering: cycle 0 is the cycle in which `load`=1 is sampled, in IDLE.
- Cycle 1: WAIT, `busy`=1.
- With `ready_in`=1 during cycle 1:
  - Cycle 2: `start`=1.
  - Cycles 3..2+PRE_W: preamble.
  - Cycles 3+PRE_W..2+PRE_W+DATA_W: payload.
  - Next GAP_CYC cycles: zeros.
  - Following cycle: `done`=1, `busy`=0.
- Defaults: `start` in cycle 2, preamble in cycles 3–6, data in cycles 7–14, gap in cycles 15–16, `done` in cycle 17.
- Minimum frame period, load to load: 3+PRE_W+DATA_W+GAP_CYC cycles (17 with defaults).
- Each extra WAIT cycle delays every later event by exactly one cycle.

## Test plan
- Reset: hold `rst`=0 with random inputs → `start`, `serialout`, `busy`, `done` all 0. Release → outputs stay 0 until `load`.
- Basic frame: `ready_in`=1, `load` with 8'hA5 in cycle 0 → `start` in cycle 2; `serialout` over cycles 3–14 = 1101_10100101; 0 in cycles 15–16; `done` pulse in cycle 17; `busy` high in cycles 1–16.
- Ready stall: `ready_in`=0 for 5 cycles after `load` → `busy`=1 and `serialout`=0 throughout; `start` 1 cycle after `ready_in` rises; frame otherwise identical to the basic frame.
- Load while busy: pulse `load` with 8'hFF during the DATA state of an 8'h3C frame → the 8'h3C frame completes unchanged, and no second frame follows.
- Reset mid-frame: assert `rst` during payload bit 3 → outputs go to 0 immediately with no `done`; a new `load` afterward produces a complete, correct frame.
- Back-to-back: `load` 8'h81 in cycle 0 and 8'h7E held high through the `done` cycle (17) → second `start` in cycle 19; both payloads correct.
